// File: rtl/ts3d_accel_if.sv
// Host-side bus of the TS3D sparse compute tile: four global-buffer write
// ports plus the two registered result read ports.
interface ts3d_accel_if #(
    parameter int DATA_WIDTH          = 8,
    parameter int BLOCK_DEPTH         = 32,
    parameter int GBFACT_ADDRWIDTH    = 8,
    parameter int GBFWEI_ADDRWIDTH    = 8,
    parameter int GBFWEI_DATAWIDTH    = 8,
    parameter int GBFFLGWEI_DATAWIDTH = 32,
    parameter int PORT_DATAWIDTH      = 32,
    parameter int GBFOFM_ADDRWIDTH    = 3,
    parameter int GBFFLGOFM_ADDRWIDTH = 1
);
    logic                           GBFWEI_Val;
    logic                           GBFWEI_EnWr;
    logic [GBFWEI_ADDRWIDTH-1:0]    GBFWEI_AddrWr;
    logic [GBFWEI_DATAWIDTH-1:0]    GBFWEI_DatWr;
    logic                           GBFFLGWEI_Val;
    logic                           GBFFLGWEI_EnWr;
    logic [GBFWEI_ADDRWIDTH-1:0]    GBFFLGWEI_AddrWr;
    logic [GBFFLGWEI_DATAWIDTH-1:0] GBFFLGWEI_DatWr;
    logic                           GBFACT_Val;
    logic                           GBFACT_EnWr;
    logic [GBFACT_ADDRWIDTH-1:0]    GBFACT_AddrWr;
    logic [DATA_WIDTH-1:0]          GBFACT_DatWr;
    logic                           GBFFLGACT_Val;
    logic                           GBFFLGACT_EnWr;
    logic [GBFACT_ADDRWIDTH-1:0]    GBFFLGACT_AddrWr;
    logic [BLOCK_DEPTH-1:0]         GBFFLGACT_DatWr;
    logic                           GBFOFM_EnRd;
    logic [GBFOFM_ADDRWIDTH-1:0]    GBFOFM_AddrRd;
    logic [PORT_DATAWIDTH-1:0]      GBFOFM_DatRd;
    logic                           GBFFLGOFM_EnRd;
    logic [GBFFLGOFM_ADDRWIDTH-1:0] GBFFLGOFM_AddrRd;
    logic [PORT_DATAWIDTH-1:0]      GBFFLGOFM_DatRd;

    modport master (
        output GBFWEI_Val, GBFWEI_EnWr, GBFWEI_AddrWr, GBFWEI_DatWr,
        output GBFFLGWEI_Val, GBFFLGWEI_EnWr, GBFFLGWEI_AddrWr, GBFFLGWEI_DatWr,
        output GBFACT_Val, GBFACT_EnWr, GBFACT_AddrWr, GBFACT_DatWr,
        output GBFFLGACT_Val, GBFFLGACT_EnWr, GBFFLGACT_AddrWr, GBFFLGACT_DatWr,
        output GBFOFM_EnRd, GBFOFM_AddrRd, GBFFLGOFM_EnRd, GBFFLGOFM_AddrRd,
        input  GBFOFM_DatRd, GBFFLGOFM_DatRd
    );

    modport slave (
        input  GBFWEI_Val, GBFWEI_EnWr, GBFWEI_AddrWr, GBFWEI_DatWr,
        input  GBFFLGWEI_Val, GBFFLGWEI_EnWr, GBFFLGWEI_AddrWr, GBFFLGWEI_DatWr,
        input  GBFACT_Val, GBFACT_EnWr, GBFACT_AddrWr, GBFACT_DatWr,
        input  GBFFLGACT_Val, GBFFLGACT_EnWr, GBFFLGACT_AddrWr, GBFFLGACT_DatWr,
        input  GBFOFM_EnRd, GBFOFM_AddrRd, GBFFLGOFM_EnRd, GBFFLGOFM_AddrRd,
        output GBFOFM_DatRd, GBFFLGOFM_DatRd
    );
endinterface

// File: rtl/ts3d_accel.sv
// TS3D sparse compute tile: one sparse dot product per block of BLOCK_DEPTH
// positions, results kept in an OFM buffer and a packed nonzero-flag buffer.
module ts3d_accel #(
    parameter int DATA_WIDTH          = 8,
    parameter int BLOCK_DEPTH         = 32,
    parameter int NBLK                = 8,
    parameter int GBFACT_ADDRWIDTH    = 8,
    parameter int GBFWEI_ADDRWIDTH    = 8,
    parameter int GBFWEI_DATAWIDTH    = 8,
    parameter int GBFFLGWEI_DATAWIDTH = 32,
    parameter int PORT_DATAWIDTH      = 32,
    parameter int GBFOFM_ADDRWIDTH    = 3,
    parameter int GBFFLGOFM_ADDRWIDTH = 1
) (
    input logic         clk,
    input logic         rst_n,
    ts3d_accel_if.slave bus
);
    localparam int BLK_W   = $clog2(NBLK);
    localparam int POS_W   = $clog2(BLOCK_DEPTH);
    localparam int PSUM_W  = 2 * DATA_WIDTH + POS_W + 1;
    localparam int MEM_D   = NBLK * BLOCK_DEPTH;
    localparam int OFM_D   = 1 << GBFOFM_ADDRWIDTH;
    localparam int FPACK_W = (1 << GBFFLGOFM_ADDRWIDTH) * PORT_DATAWIDTH;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_MAC   = 2'd2;
    localparam logic [1:0] ST_STORE = 2'd3;

    logic signed [DATA_WIDTH-1:0]       act_mem_r [MEM_D];
    logic signed [GBFWEI_DATAWIDTH-1:0] wei_mem_r [MEM_D];
    logic [BLOCK_DEPTH-1:0]             flg_act_mem_r [NBLK];
    logic [GBFFLGWEI_DATAWIDTH-1:0]     flg_wei_mem_r [NBLK];
    logic [PORT_DATAWIDTH-1:0]          ofm_mem_r [OFM_D];
    logic [NBLK-1:0]                    ofm_flg_r;

    logic [1:0]                         state_r;
    logic                               allval_d_r;
    logic [BLK_W-1:0]                   blk_r;
    logic [POS_W-1:0]                   pos_r;
    logic [POS_W-1:0]                   idx_a_r;
    logic [POS_W-1:0]                   idx_w_r;
    logic [BLOCK_DEPTH-1:0]             flg_a_r;
    logic [GBFFLGWEI_DATAWIDTH-1:0]     flg_w_r;
    logic signed [PSUM_W-1:0]           psum_r;

    logic                               allval_s;
    logic                               idle_s;
    logic                               hit_s;
    logic signed [DATA_WIDTH-1:0]       act_rd_s;
    logic signed [GBFWEI_DATAWIDTH-1:0] wei_rd_s;
    logic signed [2*DATA_WIDTH-1:0]     prod_s;
    logic [FPACK_W-1:0]                 flg_pack_s;

    // Start qualifier, compressed-operand fetch, product and flag packing.
    always_comb begin
        allval_s = bus.GBFWEI_Val & bus.GBFFLGWEI_Val & bus.GBFACT_Val & bus.GBFFLGACT_Val;
        idle_s   = (state_r == ST_IDLE);
        act_rd_s = act_mem_r[{blk_r, idx_a_r}];
        wei_rd_s = wei_mem_r[{blk_r, idx_w_r}];
        prod_s   = act_rd_s * wei_rd_s;
        if (flg_a_r[pos_r] && flg_w_r[pos_r]) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
        flg_pack_s            = '0;
        flg_pack_s[NBLK-1:0]  = ofm_flg_r;
    end

    // Host buffer writes; the contents are operand storage and are never reset.
    always_ff @(posedge clk) begin
        if (idle_s) begin
            if (bus.GBFACT_EnWr) begin
                act_mem_r[bus.GBFACT_AddrWr] <= bus.GBFACT_DatWr;
            end
            if (bus.GBFWEI_EnWr) begin
                wei_mem_r[bus.GBFWEI_AddrWr] <= bus.GBFWEI_DatWr;
            end
            if (bus.GBFFLGACT_EnWr && (bus.GBFFLGACT_AddrWr < GBFACT_ADDRWIDTH'(NBLK))) begin
                flg_act_mem_r[bus.GBFFLGACT_AddrWr[BLK_W-1:0]] <= bus.GBFFLGACT_DatWr;
            end
            if (bus.GBFFLGWEI_EnWr && (bus.GBFFLGWEI_AddrWr < GBFWEI_ADDRWIDTH'(NBLK))) begin
                flg_wei_mem_r[bus.GBFFLGWEI_AddrWr[BLK_W-1:0]] <= bus.GBFFLGWEI_DatWr;
            end
        end
    end

    // Pass sequencer: LOAD latches flags, MAC walks every position, STORE commits.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_r    <= ST_IDLE;
            allval_d_r <= 1'b0;
            blk_r      <= '0;
            pos_r      <= '0;
            idx_a_r    <= '0;
            idx_w_r    <= '0;
            flg_a_r    <= '0;
            flg_w_r    <= '0;
            psum_r     <= '0;
            ofm_flg_r  <= '0;
            for (int i = 0; i < OFM_D; i++) begin
                ofm_mem_r[i] <= '0;
            end
        end else begin
            allval_d_r <= allval_s;
            case (state_r)
                ST_IDLE: begin
                    if (allval_s && !allval_d_r) begin
                        blk_r   <= '0;
                        state_r <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    flg_a_r <= flg_act_mem_r[blk_r];
                    flg_w_r <= flg_wei_mem_r[blk_r];
                    psum_r  <= '0;
                    idx_a_r <= '0;
                    idx_w_r <= '0;
                    pos_r   <= '0;
                    state_r <= ST_MAC;
                end
                ST_MAC: begin
                    if (hit_s) begin
                        psum_r <= psum_r + PSUM_W'(prod_s);
                    end
                    if (flg_a_r[pos_r]) begin
                        idx_a_r <= idx_a_r + POS_W'(1);
                    end
                    if (flg_w_r[pos_r]) begin
                        idx_w_r <= idx_w_r + POS_W'(1);
                    end
                    pos_r <= pos_r + POS_W'(1);
                    if (pos_r == POS_W'(BLOCK_DEPTH - 1)) begin
                        state_r <= ST_STORE;
                    end
                end
                ST_STORE: begin
                    ofm_mem_r[blk_r] <= PORT_DATAWIDTH'(psum_r);
                    ofm_flg_r[blk_r] <= (psum_r != '0);
                    if (blk_r == BLK_W'(NBLK - 1)) begin
                        state_r <= ST_IDLE;
                    end else begin
                        blk_r   <= blk_r + BLK_W'(1);
                        state_r <= ST_LOAD;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Registered result read ports; a read racing its STORE sees the old entry.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            bus.GBFOFM_DatRd    <= '0;
            bus.GBFFLGOFM_DatRd <= '0;
        end else begin
            if (bus.GBFOFM_EnRd) begin
                bus.GBFOFM_DatRd <= ofm_mem_r[bus.GBFOFM_AddrRd];
            end
            if (bus.GBFFLGOFM_EnRd) begin
                bus.GBFFLGOFM_DatRd <= flg_pack_s[bus.GBFFLGOFM_AddrRd * PORT_DATAWIDTH +: PORT_DATAWIDTH];
            end
        end
    end
endmodule

// File: tb/tb_ts3d_accel.sv
// Directed/randomized bench for ts3d_accel; expected results come from a dense
// dot-product model of each block.
module tb_ts3d_accel;
    localparam int BD   = 32;
    localparam int NB   = 8;
    localparam int PASS = NB * (BD + 2);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ts3d_accel_if bus ();
    ts3d_accel dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    int checks = 0;
    int errors = 0;

    logic [31:0] m_fa [NB];
    logic [31:0] m_fw [NB];
    int          m_act [NB][BD];
    int          m_wei [NB][BD];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int exp_ofm(input int b);
        int sum = 0;
        for (int p = 0; p < BD; p++) begin
            if (m_fa[b][p] && m_fw[b][p]) sum += m_act[b][p] * m_wei[b][p];
        end
        return sum;
    endfunction

    function automatic logic [31:0] exp_flg0();
        logic [31:0] w = 32'h0;
        for (int b = 0; b < NB; b++) w[b] = (exp_ofm(b) != 0);
        return w;
    endfunction

    task automatic rand_block(input int b);
        m_fa[b] = $urandom;
        m_fw[b] = $urandom;
        for (int p = 0; p < BD; p++) begin
            m_act[b][p] = int'($urandom_range(255, 0)) - 128;
            m_wei[b][p] = int'($urandom_range(255, 0)) - 128;
        end
    endtask

    task automatic fill_block(input int b, input logic [31:0] fa, input logic [31:0] fw,
                              input int a, input int w);
        m_fa[b] = fa;
        m_fw[b] = fw;
        for (int p = 0; p < BD; p++) begin
            m_act[b][p] = a;
            m_wei[b][p] = w;
        end
    endtask

    // Host packing: the k-th set flag of block b goes to address b*BD+k.
    task automatic push_block(input int b);
        int ka = 0;
        int kw = 0;
        @(negedge clk);
        bus.GBFFLGACT_EnWr = 1'b1; bus.GBFFLGACT_AddrWr = 8'(b); bus.GBFFLGACT_DatWr = m_fa[b];
        bus.GBFFLGWEI_EnWr = 1'b1; bus.GBFFLGWEI_AddrWr = 8'(b); bus.GBFFLGWEI_DatWr = m_fw[b];
        for (int p = 0; p < BD; p++) begin
            @(negedge clk);
            bus.GBFFLGACT_EnWr = 1'b0;
            bus.GBFFLGWEI_EnWr = 1'b0;
            bus.GBFACT_EnWr   = m_fa[b][p];
            bus.GBFACT_AddrWr = 8'(b * BD + ka);
            bus.GBFACT_DatWr  = 8'(m_act[b][p]);
            bus.GBFWEI_EnWr   = m_fw[b][p];
            bus.GBFWEI_AddrWr = 8'(b * BD + kw);
            bus.GBFWEI_DatWr  = 8'(m_wei[b][p]);
            if (m_fa[b][p]) ka++;
            if (m_fw[b][p]) kw++;
        end
        @(negedge clk);
        bus.GBFACT_EnWr = 1'b0;
        bus.GBFWEI_EnWr = 1'b0;
    endtask

    task automatic set_vals(input logic v);
        @(negedge clk);
        bus.GBFWEI_Val = v; bus.GBFFLGWEI_Val = v; bus.GBFACT_Val = v; bus.GBFFLGACT_Val = v;
    endtask

    task automatic rd_ofm(input int a, output logic [31:0] d);
        @(negedge clk);
        bus.GBFOFM_EnRd = 1'b1; bus.GBFOFM_AddrRd = 3'(a);
        @(negedge clk);
        bus.GBFOFM_EnRd = 1'b0;
        d = bus.GBFOFM_DatRd;
    endtask

    task automatic rd_flg(input int a, output logic [31:0] d);
        @(negedge clk);
        bus.GBFFLGOFM_EnRd = 1'b1; bus.GBFFLGOFM_AddrRd = 1'(a);
        @(negedge clk);
        bus.GBFFLGOFM_EnRd = 1'b0;
        d = bus.GBFFLGOFM_DatRd;
    endtask

    task automatic check_all(input string tag, input logic zero);
        logic [31:0] d;
        for (int b = 0; b < NB; b++) begin
            rd_ofm(b, d);
            chk($sformatf("%s_ofm%0d", tag, b), d, zero ? 32'h0 : 32'(exp_ofm(b)));
        end
        rd_flg(0, d);
        chk($sformatf("%s_flg0", tag), d, zero ? 32'h0 : exp_flg0());
        rd_flg(1, d);
        chk($sformatf("%s_flg1", tag), d, 32'h0);
    endtask

    task automatic run_pass();
        set_vals(1'b1);
        repeat (PASS + 4) @(negedge clk);
    endtask

    initial begin
        logic [31:0] d;
        rst_n = 1'b1;
        bus.GBFWEI_Val = 1'b0; bus.GBFWEI_EnWr = 1'b0; bus.GBFWEI_AddrWr = 8'h0; bus.GBFWEI_DatWr = 8'h0;
        bus.GBFFLGWEI_Val = 1'b0; bus.GBFFLGWEI_EnWr = 1'b0; bus.GBFFLGWEI_AddrWr = 8'h0; bus.GBFFLGWEI_DatWr = 32'h0;
        bus.GBFACT_Val = 1'b0; bus.GBFACT_EnWr = 1'b0; bus.GBFACT_AddrWr = 8'h0; bus.GBFACT_DatWr = 8'h0;
        bus.GBFFLGACT_Val = 1'b0; bus.GBFFLGACT_EnWr = 1'b0; bus.GBFFLGACT_AddrWr = 8'h0; bus.GBFFLGACT_DatWr = 32'h0;
        bus.GBFOFM_EnRd = 1'b0; bus.GBFOFM_AddrRd = 3'h0; bus.GBFFLGOFM_EnRd = 1'b0; bus.GBFFLGOFM_AddrRd = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_datrd", bus.GBFOFM_DatRd, 32'h0);
        chk("rst_flgrd", bus.GBFFLGOFM_DatRd, 32'h0);
        rst_n = 1'b0;
        check_all("reset", 1'b1);

        // Dense block 0 plus random blocks.
        for (int b = 1; b < NB; b++) rand_block(b);
        fill_block(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 2);
        for (int b = 0; b < NB; b++) push_block(b);
        run_pass();
        rd_ofm(0, d);
        chk("dense_64", d, 32'd64);
        check_all("dense", 1'b0);
        rd_ofm(3, d);
        @(negedge clk);
        bus.GBFOFM_AddrRd = 3'd5;
        @(negedge clk);
        chk("hold_datrd", bus.GBFOFM_DatRd, 32'(exp_ofm(3)));
        set_vals(1'b0);

        // Sparse alignment, no overlap, and an out-of-range flag write.
        fill_block(0, 32'h0000_0005, 32'h0000_0006, 0, 0);
        m_act[0][0] = 3; m_act[0][2] = -4; m_wei[0][1] = 5; m_wei[0][2] = 7;
        fill_block(5, 32'h0000_000F, 32'h0000_00F0, 9, 9);
        push_block(0);
        push_block(5);
        @(negedge clk);
        bus.GBFFLGACT_EnWr = 1'b1; bus.GBFFLGACT_AddrWr = 8'd8; bus.GBFFLGACT_DatWr = 32'h0;
        bus.GBFFLGWEI_EnWr = 1'b1; bus.GBFFLGWEI_AddrWr = 8'd8; bus.GBFFLGWEI_DatWr = 32'h0;
        @(negedge clk);
        bus.GBFFLGACT_EnWr = 1'b0; bus.GBFFLGWEI_EnWr = 1'b0;
        run_pass();
        rd_ofm(0, d);
        chk("sparse_m28", d, 32'hFFFF_FFE4);
        rd_ofm(5, d);
        chk("nooverlap_0", d, 32'h0);
        check_all("sparse", 1'b0);
        set_vals(1'b0);

        // Extremes: 32 * (-128 * -128).
        fill_block(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -128, -128);
        fill_block(7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -128, -128);
        push_block(0);
        push_block(7);
        run_pass();
        rd_ofm(7, d);
        chk("extreme", d, 32'h0008_0000);
        check_all("extreme", 1'b0);
        set_vals(1'b0);

        // Writes while busy must be dropped; a fresh Val edge reruns identically.
        fill_block(6, 32'hA5A5_0F0F, 32'hFFFF_0000, 17, -3);
        push_block(6);
        set_vals(1'b1);
        repeat (50) @(negedge clk);
        bus.GBFFLGACT_EnWr = 1'b1; bus.GBFFLGACT_AddrWr = 8'd7; bus.GBFFLGACT_DatWr = 32'h0;
        bus.GBFFLGWEI_EnWr = 1'b1; bus.GBFFLGWEI_AddrWr = 8'd6; bus.GBFFLGWEI_DatWr = 32'h1;
        bus.GBFACT_EnWr = 1'b1; bus.GBFACT_AddrWr = 8'd224; bus.GBFACT_DatWr = 8'h01;
        bus.GBFWEI_EnWr = 1'b1; bus.GBFWEI_AddrWr = 8'd192; bus.GBFWEI_DatWr = 8'h01;
        @(negedge clk);
        bus.GBFFLGACT_EnWr = 1'b0; bus.GBFFLGWEI_EnWr = 1'b0;
        bus.GBFACT_EnWr = 1'b0; bus.GBFWEI_EnWr = 1'b0;
        repeat (PASS) @(negedge clk);
        check_all("gated", 1'b0);
        set_vals(1'b0);
        run_pass();
        check_all("rerun", 1'b0);

        // Reset at cycle 100 of a pass with Vals held high.
        set_vals(1'b0);
        for (int b = 0; b < NB; b++) rand_block(b);
        for (int b = 0; b < NB; b++) push_block(b);
        set_vals(1'b1);
        repeat (100) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        check_all("midrst", 1'b1);
        repeat (PASS + 4) @(negedge clk);
        check_all("restart", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ts3d_accel.md
Name: ts3d_accel

Overview:
- Top of the TS3D sparse compute tile.
- The host loads four global buffers: compressed activations, activation occupancy flags, compressed weights and weight occupancy flags.
- The block computes one sparse dot product per block of BLOCK_DEPTH positions and stores each result in an output-feature-map (OFM) buffer plus a packed nonzero-flag buffer.
- The host reads both result buffers back through registered read ports.

Parameters:
- DATA_WIDTH, 8: width of one signed activation or weight value.
- BLOCK_DEPTH, 32: positions per block; also the flag-word width.
- NBLK, 8: number of blocks per pass.
- GBFACT_ADDRWIDTH, 8: activation-buffer address width; capacity NBLK*BLOCK_DEPTH entries.
- GBFWEI_ADDRWIDTH, 8: weight-buffer address width; same capacity.
- GBFWEI_DATAWIDTH, 8: weight write width, equal to DATA_WIDTH.
- GBFFLGWEI_DATAWIDTH, 32: weight flag word width, equal to BLOCK_DEPTH.
- PORT_DATAWIDTH, 32: result read-port width.
- GBFOFM_ADDRWIDTH, 3: OFM address width, log2(NBLK).
- GBFFLGOFM_ADDRWIDTH, 1: OFM-flag address width.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-high reset (asserted = 1).
- GBFWEI_Val  in  1  weight buffer content valid.
- GBFWEI_EnWr  in  1  weight write enable.
- GBFWEI_AddrWr  in  GBFWEI_ADDRWIDTH  weight write address.
- GBFWEI_DatWr  in  GBFWEI_DATAWIDTH  weight write data.
- GBFFLGWEI_Val  in  1  weight flag buffer content valid.
- GBFFLGWEI_EnWr  in  1  weight flag write enable.
- GBFFLGWEI_AddrWr  in  GBFWEI_ADDRWIDTH  weight flag block index.
- GBFFLGWEI_DatWr  in  GBFFLGWEI_DATAWIDTH  weight flag word.
- GBFACT_Val  in  1  activation buffer content valid.
- GBFACT_EnWr  in  1  activation write enable.
- GBFACT_AddrWr  in  GBFACT_ADDRWIDTH  activation write address.
- GBFACT_DatWr  in  DATA_WIDTH  activation write data.
- GBFFLGACT_Val  in  1  activation flag buffer content valid.
- GBFFLGACT_EnWr  in  1  activation flag write enable.
- GBFFLGACT_AddrWr  in  GBFACT_ADDRWIDTH  activation flag block index.
- GBFFLGACT_DatWr  in  BLOCK_DEPTH  activation flag word.
- GBFOFM_EnRd  in  1  OFM read enable.
- GBFOFM_AddrRd  in  GBFOFM_ADDRWIDTH  OFM read address (block index).
- GBFOFM_DatRd  out  PORT_DATAWIDTH  OFM read data.
- GBFFLGOFM_EnRd  in  1  OFM flag read enable.
- GBFFLGOFM_AddrRd  in  GBFFLGOFM_ADDRWIDTH  OFM flag word address.
- GBFFLGOFM_DatRd  out  PORT_DATAWIDTH  OFM flag read data.

Behaviour:
- Storage layout: the k-th nonzero value of block b sits at address b*BLOCK_DEPTH+k in the value buffers. Flag word b: bit p=1 means position p is nonzero.
- Flag writes with index >= NBLK are ignored.
- Buffer writes take effect on the clock edge. Writes are accepted only in IDLE and ignored in BUSY.
- Start condition: AllVal = AND of the four Val inputs, with a registered copy AllVal_d (reset value 0). A pass starts in IDLE when AllVal & ~AllVal_d.
  - Holding all Vals high from reset therefore runs exactly one pass.
- States: IDLE -> LOAD -> MAC -> STORE -> (LOAD of the next block, or IDLE after block NBLK-1).
- LOAD (1 cycle): latch flag words b; clear psum, idxA and idxW.
- MAC (BLOCK_DEPTH cycles, p = 0..BLOCK_DEPTH-1):
  - If flgA[p] & flgW[p]: psum += signed(act[b*BD+idxA]) * signed(wei[b*BD+idxW]).
  - idxA increments when flgA[p]=1; idxW increments when flgW[p]=1.
- STORE (1 cycle): OFM[b] = psum sign-extended to PORT_DATAWIDTH; OFM flag bit b = (psum != 0).
- Pass length is NBLK*(BLOCK_DEPTH+2) cycles: 272 with default parameters.
- psum is a signed accumulator of 2*DATA_WIDTH+log2(BLOCK_DEPTH)+1 = 22 bits and never overflows.
- OFM flag packing: word w, bit i = block 32*w+i. With the defaults only word 0 is used; word 1 reads 0.
- Reads: data appears on DatRd one cycle after EnRd. DatRd holds its value when EnRd=0. Reads are allowed in any state.
  - A read of entry b in the same cycle as its STORE returns the old value.
- Reset: state IDLE; AllVal_d=0; psum and counters 0; GBFOFM_DatRd=0 and GBFFLGOFM_DatRd=0; OFM and OFM flag contents cleared to 0.
  - Value and flag buffers are not reset.
  - Reset mid-pass aborts the pass immediately; already-stored blocks are cleared.
- A Val dropping mid-pass does not abort the pass. The next pass needs AllVal to fall and rise again.

Test Plan:
- Dense match: block 0 flags both 0xFFFFFFFF, all act=1 and wei=2 -> after 272 cycles, OFM[0]=64 and OFM flag word 0 bit 0 = 1.
- Sparse alignment:
  - Inputs: flgA[0]=0x00000005 with act values 3,-4; flgW[0]=0x00000006 with wei values 5,7.
  - Result: only position 2 matches, so OFM[0] = (-4)*7 = -28 = 0xFFFFFFE4.
- No overlap: flgA=0x0000000F, flgW=0x000000F0 -> OFM[b]=0 and flag bit b = 0.
- Extremes: full flags, act=-128 and wei=-128 for all 32 positions -> OFM = 524288 = 0x00080000 with no overflow.
- Write gating: a write issued during BUSY changes nothing; a new AllVal low->high edge reruns the pass with identical results.
- Reset mid-pass at cycle 100 -> all OFM reads return 0 and state is IDLE; with Vals held high a new pass starts.
